// File: rtl/nibble_readout_pkg.sv
// Shared constants, state encoding and scan helper for the nibble readout block.
package nibble_readout_pkg;

    localparam int NIBBLE_W = 4;
    localparam int IDX_W    = 2;
    localparam int OPER_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int PTR_W    = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_PRESENT = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } scan_t;

    // Lowest selected register at or above ptr; ptr may sit one past the last register.
    function automatic scan_t next_sel(input logic [NUM_REGS-1:0] mask, input logic [PTR_W-1:0] ptr);
        scan_t res;
        res.found = 1'b0;
        res.idx   = {IDX_W{1'b0}};
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= ptr)) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer for asynchronous pin inputs.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_r;

    // Shift chain clocking the asynchronous level into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {STAGES{1'b0}};
        end else begin
            stage_r <= {stage_r[STAGES-2:0], d};
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/nibble_readout.sv
// Reads back up to four operand nibbles to an external reader over a 4-phase valid/ack handshake.
module nibble_readout
    import nibble_readout_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_REGS-1:0] sel_mask,
    input  logic [OPER_W-1:0]   in1,
    input  logic [OPER_W-1:0]   in2,
    input  logic [OPER_W-1:0]   in3,
    input  logic [OPER_W-1:0]   in4,
    input  logic                ack,
    output logic [NIBBLE_W-1:0] data_out,
    output logic [IDX_W-1:0]    idx,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TO_EN    = (TIMEOUT != 0);

    logic [2:0]                        state_r;
    logic [NUM_REGS-1:0][OPER_W-1:0]   snap_r;
    logic [NUM_REGS-1:0]               mask_r;
    logic [PTR_W-1:0]                  ptr_r;
    logic [CNT_W-1:0]                  cnt_r;
    logic [NIBBLE_W-1:0]               data_r;
    logic [IDX_W-1:0]                  idx_r;
    logic                              valid_r;
    logic                              busy_r;
    logic                              done_r;
    logic                              err_r;
    logic                              ack_sync_s;
    logic                              tmo_s;
    scan_t                             scan_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_sync_s)
    );

    // Next selected register and phase-timeout detection.
    always_comb begin
        scan_s = next_sel(mask_r, ptr_r);
        tmo_s  = 1'b0;
        if (TO_EN && (cnt_r == CNT_LAST)) begin
            tmo_s = 1'b1;
        end else begin
            tmo_s = 1'b0;
        end
    end

    // Burst sequencer: snapshot, scan, handshake each selected nibble, then finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            snap_r  <= {(NUM_REGS * OPER_W){1'b0}};
            mask_r  <= {NUM_REGS{1'b0}};
            ptr_r   <= {PTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            data_r  <= {NIBBLE_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        snap_r  <= {in4, in3, in2, in1};
                        mask_r  <= sel_mask;
                        err_r   <= 1'b0;
                        ptr_r   <= {PTR_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_s.found) begin
                        data_r  <= snap_r[scan_s.idx];
                        idx_r   <= scan_s.idx;
                        valid_r <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_PRESENT;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
                    end
                end
                ST_PRESENT: begin
                    if (ack_sync_s) begin
                        valid_r <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_RELEASE;
                    end else if (tmo_s) begin
                        err_r   <= 1'b1;
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!ack_sync_s) begin
                        ptr_r   <= PTR_W'(idx_r) + 3'd1;
                        state_r <= ST_SCAN;
                    end else if (tmo_s) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = data_r;
    assign idx      = idx_r;
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_nibble_readout.sv
// Self-checking bench for nibble_readout: directed vector table, reset/start corner cases, random bursts.
module tb_nibble_readout;

    localparam int TMO       = 10;
    localparam int SYNC      = 2;
    // Longest reader response (cycles after seeing a level) that still beats the phase timeout.
    localparam int ACK_LIMIT = TMO - SYNC - 1;

    logic       clk = 1'b0;
    logic       rst, start, ack;
    logic [3:0] sel_mask, in1, in2, in3, in4;
    logic [3:0] data_out;
    logic [1:0] idx;
    logic       valid, busy, done, err;

    always #5 clk = ~clk;

    nibble_readout #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_mask(sel_mask),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .ack(ack),
        .data_out(data_out), .idx(idx), .valid(valid), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  mask;
        int          ack_dly;
        int          rel_dly;
        int          exp_n;
        logic        exp_err;
        int          exp_vcyc;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] obs_idx[$];
    logic [3:0] obs_dat[$];
    int         done_cnt, done_at, first_valid_at, busy_cyc, valid_cyc;
    logic       err_at_start, stable_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input logic lvl, input string name);
        int n = 0;
        while (valid !== lvl && n < 50) begin
            tick();
            n++;
        end
        check(name, {31'd0, valid}, {31'd0, lvl});
    endtask

    // One burst with a behavioural 4-phase reader; optional mid-burst operand change plus stray start.
    task automatic run_burst(input logic [15:0] ins, input logic [3:0] mask,
                             input int ack_dly, input int rel_dly, input int mut_cyc);
        int phase = 0;
        int cnt   = 0;
        logic [1:0] hold_idx = 2'd0;
        logic [3:0] hold_dat = 4'd0;
        obs_idx.delete();
        obs_dat.delete();
        done_cnt = 0; done_at = -1; first_valid_at = -1;
        busy_cyc = 0; valid_cyc = 0; stable_ok = 1'b1;
        {in4, in3, in2, in1} = ins;
        sel_mask = mask;
        ack      = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        err_at_start = err;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == mut_cyc) begin
                in1      = 4'h9;
                sel_mask = ~mask;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (valid) valid_cyc++;
            if (valid && first_valid_at < 0) first_valid_at = cyc;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            case (phase)
                0: if (valid) begin
                    obs_idx.push_back(idx);
                    obs_dat.push_back(data_out);
                    hold_idx = idx;
                    hold_dat = data_out;
                    if (ack_dly == 0) begin ack = 1'b1; phase = 2; end
                    else begin cnt = ack_dly; phase = 1; end
                end
                1: if (!valid) begin
                    phase = 0;
                end else begin
                    if (idx !== hold_idx || data_out !== hold_dat) stable_ok = 1'b0;
                    cnt--;
                    if (cnt == 0) begin ack = 1'b1; phase = 2; end
                end
                2: if (!valid) begin
                    if (rel_dly == 0) begin ack = 1'b0; phase = 0; end
                    else begin cnt = rel_dly; phase = 3; end
                end else if (idx !== hold_idx || data_out !== hold_dat) begin
                    stable_ok = 1'b0;
                end
                3: begin
                    cnt--;
                    if (cnt == 0) begin ack = 1'b0; phase = 0; end
                end
                default: phase = 0;
            endcase
            if (done_at >= 0 && cyc > done_at) break;
            tick();
        end
        start = 1'b0;
        ack   = 1'b0;
        check("done_seen", {31'd0, done_at >= 0}, 32'd1);
        repeat (4) tick();
    endtask

    task automatic apply_checks(input string tag, input logic [15:0] ins, input logic [3:0] mask,
                                input int exp_n, input logic exp_err, input int exp_vcyc);
        int k = 0;
        check({tag, "_n"}, obs_idx.size(), exp_n);
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                if (k < exp_n && k < obs_idx.size()) begin
                    check($sformatf("%s_idx%0d", tag, k), {30'd0, obs_idx[k]}, b);
                    check($sformatf("%s_dat%0d", tag, k), {28'd0, obs_dat[k]}, {28'd0, ins[4*b +: 4]});
                end
                k++;
            end
        end
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_err_clr"}, {31'd0, err_at_start}, 32'd0);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        check({tag, "_stable"}, {31'd0, stable_ok}, 32'd1);
        check({tag, "_idle"}, {30'd0, busy, valid}, 32'd0);
        if (exp_vcyc >= 0) check({tag, "_vcyc"}, valid_cyc, exp_vcyc);
        if (mask[0]) check({tag, "_lat"}, first_valid_at, 32'd2);
        if (mask == 4'd0) begin
            check({tag, "_done_at"}, done_at, 32'd2);
            check({tag, "_busy_cyc"}, busy_cyc, 32'd2);
        end
        if (obs_dat.size() > 0) begin
            check({tag, "_hold"}, {26'd0, idx, data_out}, {26'd0, obs_idx[$], obs_dat[$]});
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [15:0] r_ins;
        logic [3:0]  r_mask;
        int          r_dly, r_rel, r_n;
        logic        r_err;

        vecs[0] = '{16'hF5A3, 4'b1111, 3,    1, 4, 1'b0, -1};
        vecs[1] = '{16'hC070, 4'b1010, 3,    2, 2, 1'b0, -1};
        vecs[2] = '{16'h1234, 4'b0000, 0,    0, 0, 1'b0, -1};
        vecs[3] = '{16'h000B, 4'b0001, 7,    0, 1, 1'b0, -1};
        vecs[4] = '{16'h000D, 4'b0001, 8,    0, 1, 1'b1, 10};
        vecs[5] = '{16'h6000, 4'b1000, 0,    0, 1, 1'b0, -1};
        vecs[6] = '{16'h0E00, 4'b0100, 2,    8, 1, 1'b1, -1};
        vecs[7] = '{16'h0004, 4'b0001, 1000, 0, 1, 1'b1, 10};

        rst = 1'b1; start = 1'b0; ack = 1'b0; sel_mask = 4'd0;
        in1 = 4'd0; in2 = 4'd0; in3 = 4'd0; in4 = 4'd0;
        repeat (3) tick();
        check("reset_outputs", {23'd0, data_out, idx, valid, busy, done, err}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i].ins, vecs[i].mask, vecs[i].ack_dly, vecs[i].rel_dly, -1);
            apply_checks($sformatf("vec%0d", i), vecs[i].ins, vecs[i].mask,
                         vecs[i].exp_n, vecs[i].exp_err, vecs[i].exp_vcyc);
        end

        // Operand change and stray start mid-burst must not disturb the snapshot.
        run_burst(16'hF5A3, 4'b1111, 2, 1, 3);
        apply_checks("midchg", 16'hF5A3, 4'b1111, 4, 1'b0, -1);

        // Reset while releasing idx 1, with a simultaneous start that must be ignored.
        {in4, in3, in2, in1} = 16'hF5A3; sel_mask = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(1'b1, "rst_v0_up");
        ack = 1'b1;
        wait_valid(1'b0, "rst_v0_dn");
        ack = 1'b0;
        wait_valid(1'b1, "rst_v1_up");
        check("rst_pre_idx", {30'd0, idx}, 32'd1);
        ack = 1'b1;
        wait_valid(1'b0, "rst_v1_dn");
        rst = 1'b1; start = 1'b1;
        tick();
        check("rst_mid_outputs", {23'd0, data_out, idx, valid, busy, done, err}, 32'd0);
        rst = 1'b0; start = 1'b0; ack = 1'b0;
        repeat (3) tick();
        check("rst_start_ignored", {30'd0, busy, valid}, 32'd0);
        run_burst(16'h8421, 4'b1111, 1, 0, -1);
        apply_checks("post_rst", 16'h8421, 4'b1111, 4, 1'b0, -1);

        // Random bursts against the transfer-list model.
        for (int r = 0; r < 30; r++) begin
            r_ins  = 16'($urandom);
            r_mask = 4'($urandom_range(0, 15));
            r_dly  = $urandom_range(0, 9);
            r_rel  = $urandom_range(0, 9);
            if (r_mask == 4'd0) begin
                r_n = 0; r_err = 1'b0;
            end else if (r_dly > ACK_LIMIT || r_rel > ACK_LIMIT) begin
                r_n = 1; r_err = 1'b1;
            end else begin
                r_n = $countones(r_mask); r_err = 1'b0;
            end
            run_burst(r_ins, r_mask, r_dly, r_rel, -1);
            apply_checks($sformatf("rnd%0d", r), r_ins, r_mask, r_n, r_err, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
